// File: rtl/cpu_mem_pkg.sv
// Shared address-field geometry, block types and cache FSM states for the CPU data-memory path.
// Pure declarations: no latency, no flow control.
package cpu_mem_pkg;

    localparam int ADDR_W     = 8;
    localparam int DATA_W     = 8;
    localparam int INDEX_W    = 3;
    localparam int OFFSET_W   = 2;
    localparam int TAG_W      = ADDR_W - INDEX_W - OFFSET_W;
    localparam int BLOCK_W    = DATA_W << OFFSET_W;
    localparam int NUM_BLOCKS = 1 << INDEX_W;
    localparam int MEM_ADDR_W = TAG_W + INDEX_W;

    localparam int OFFSET_LSB = 0;
    localparam int INDEX_LSB  = OFFSET_W;
    localparam int TAG_LSB    = OFFSET_W + INDEX_W;

    typedef logic [TAG_W-1:0]    tag_t;
    typedef logic [INDEX_W-1:0]  index_t;
    typedef logic [OFFSET_W-1:0] offset_t;
    typedef logic [BLOCK_W-1:0]  block_t;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        FETCH     = 2'd2,
        ALLOCATE  = 2'd3
    } cache_state_e;

    function automatic tag_t addr_tag(input logic [ADDR_W-1:0] a);
        return a[TAG_LSB +: TAG_W];
    endfunction

    function automatic index_t addr_index(input logic [ADDR_W-1:0] a);
        return a[INDEX_LSB +: INDEX_W];
    endfunction

    function automatic offset_t addr_offset(input logic [ADDR_W-1:0] a);
        return a[OFFSET_LSB +: OFFSET_W];
    endfunction

    function automatic logic [DATA_W-1:0] block_byte(input block_t b, input offset_t o);
        return b[o*DATA_W +: DATA_W];
    endfunction

endpackage

// File: rtl/dcache_array.sv
// Data/tag/valid/dirty storage: combinational read port, synchronous byte write and block fill.
// Writes land at the next edge; no backpressure, fill wins over byte write if both are asserted.
module dcache_array
    import cpu_mem_pkg::*;
(
    input  logic              core_clk,
    input  logic              rst_n,
    input  index_t            rd_idx,
    output block_t            rd_block,
    output tag_t              rd_tag,
    output logic              rd_valid,
    output logic              rd_dirty,
    input  index_t            wr_idx,
    input  logic              byte_we,
    input  offset_t           wr_off,
    input  logic [DATA_W-1:0] wr_byte,
    input  logic              fill_we,
    input  tag_t              fill_tag,
    input  block_t            fill_block
);

    block_t                  data_q [NUM_BLOCKS];
    block_t                  data_d [NUM_BLOCKS];
    tag_t                    tag_q  [NUM_BLOCKS];
    tag_t                    tag_d  [NUM_BLOCKS];
    logic [NUM_BLOCKS-1:0]   valid_q, valid_d;
    logic [NUM_BLOCKS-1:0]   dirty_q, dirty_d;

    always_comb begin
        data_d  = data_q;
        tag_d   = tag_q;
        valid_d = valid_q;
        dirty_d = dirty_q;
        if (fill_we) begin
            data_d[wr_idx]  = fill_block;
            tag_d[wr_idx]   = fill_tag;
            valid_d[wr_idx] = 1'b1;
            dirty_d[wr_idx] = 1'b0;
        end else if (byte_we) begin
            data_d[wr_idx][wr_off*DATA_W +: DATA_W] = wr_byte;
            dirty_d[wr_idx] = 1'b1;
        end
    end

    // Only the status bits are reset; stale data/tags are harmless once valid is clear.
    always_ff @(posedge core_clk) begin
        if (!rst_n) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            valid_q <= valid_d;
            dirty_q <= dirty_d;
        end
    end

    always_ff @(posedge core_clk) begin
        data_q <= data_d;
        tag_q  <= tag_d;
    end

    assign rd_block = data_q[rd_idx];
    assign rd_tag   = tag_q[rd_idx];
    assign rd_valid = valid_q[rd_idx];
    assign rd_dirty = dirty_q[rd_idx];

endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped write-back/write-allocate D-cache: hits in 0 stall cycles; miss = detect + writeback + fetch + allocate.
// BUSYWAIT stalls the CPU during a miss; memory transfers complete on the first edge MEM_BUSYWAIT is low.
module dcache_controller
    import cpu_mem_pkg::*;
(
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  READ,
    input  logic                  WRITE,
    input  logic [ADDR_W-1:0]     ADDRESS,
    input  logic [DATA_W-1:0]     WRITEDATA,
    output logic [DATA_W-1:0]     READDATA,
    output logic                  BUSYWAIT,
    output logic                  MEM_READ,
    output logic                  MEM_WRITE,
    output logic [MEM_ADDR_W-1:0] MEM_ADDRESS,
    output logic [BLOCK_W-1:0]    MEM_WRITEDATA,
    input  logic [BLOCK_W-1:0]    MEM_READDATA,
    input  logic                  MEM_BUSYWAIT
);

    cache_state_e state_q, state_d;
    tag_t         miss_tag_q, miss_tag_d;
    index_t       miss_idx_q, miss_idx_d;
    block_t       fill_q, fill_d;

    index_t       rd_idx;
    block_t       rd_block;
    tag_t         rd_tag;
    logic         rd_valid;
    logic         rd_dirty;
    logic         req;
    logic         hit;
    logic         byte_we;
    logic         fill_we;

    dcache_array u_array (
        .core_clk   (CLK),
        .rst_n      (RESET),
        .rd_idx     (rd_idx),
        .rd_block   (rd_block),
        .rd_tag     (rd_tag),
        .rd_valid   (rd_valid),
        .rd_dirty   (rd_dirty),
        .wr_idx     (rd_idx),
        .byte_we    (byte_we),
        .wr_off     (addr_offset(ADDRESS)),
        .wr_byte    (WRITEDATA),
        .fill_we    (fill_we),
        .fill_tag   (miss_tag_q),
        .fill_block (fill_q)
    );

    // The miss line is latched so a request dropped mid-miss still finishes cleanly.
    always_comb begin
        req      = READ | WRITE;
        rd_idx   = (state_q == IDLE) ? addr_index(ADDRESS) : miss_idx_q;
        hit      = (state_q == IDLE) & rd_valid & (rd_tag == addr_tag(ADDRESS));
        BUSYWAIT = req & ~hit;
        READDATA = hit ? block_byte(rd_block, addr_offset(ADDRESS)) : '0;
        byte_we  = hit & WRITE;
    end

    always_comb begin
        state_d       = state_q;
        miss_tag_d    = miss_tag_q;
        miss_idx_d    = miss_idx_q;
        fill_d        = fill_q;
        fill_we       = 1'b0;
        MEM_READ      = 1'b0;
        MEM_WRITE     = 1'b0;
        MEM_ADDRESS   = '0;
        MEM_WRITEDATA = '0;
        case (state_q)
            IDLE: begin
                if (req && !hit) begin
                    miss_tag_d = addr_tag(ADDRESS);
                    miss_idx_d = addr_index(ADDRESS);
                    state_d    = rd_dirty ? WRITEBACK : FETCH;
                end
            end
            WRITEBACK: begin
                MEM_WRITE     = 1'b1;
                MEM_ADDRESS   = {rd_tag, miss_idx_q};
                MEM_WRITEDATA = rd_block;
                if (!MEM_BUSYWAIT) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                MEM_READ    = 1'b1;
                MEM_ADDRESS = {miss_tag_q, miss_idx_q};
                if (!MEM_BUSYWAIT) begin
                    fill_d  = MEM_READDATA;
                    state_d = ALLOCATE;
                end
            end
            ALLOCATE: begin
                fill_we = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q    <= IDLE;
            miss_tag_q <= '0;
            miss_idx_q <= '0;
            fill_q     <= '0;
        end else begin
            state_q    <= state_d;
            miss_tag_q <= miss_tag_d;
            miss_idx_q <= miss_idx_d;
            fill_q     <= fill_d;
        end
    end

endmodule

// File: tb/tb_dcache_controller.sv
// Directed bench for dcache_controller with a 3-busy-cycle block memory model.
module tb_dcache_controller;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        READ;
    logic        WRITE;
    logic [7:0]  ADDRESS;
    logic [7:0]  WRITEDATA;
    logic [7:0]  READDATA;
    logic        BUSYWAIT;
    logic        MEM_READ;
    logic        MEM_WRITE;
    logic [5:0]  MEM_ADDRESS;
    logic [31:0] MEM_WRITEDATA;
    logic [31:0] MEM_READDATA;
    logic        MEM_BUSYWAIT;

    int n_checks = 0;
    int n_pass   = 0;

    dcache_controller dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .READ          (READ),
        .WRITE         (WRITE),
        .ADDRESS       (ADDRESS),
        .WRITEDATA     (WRITEDATA),
        .READDATA      (READDATA),
        .BUSYWAIT      (BUSYWAIT),
        .MEM_READ      (MEM_READ),
        .MEM_WRITE     (MEM_WRITE),
        .MEM_ADDRESS   (MEM_ADDRESS),
        .MEM_WRITEDATA (MEM_WRITEDATA),
        .MEM_READDATA  (MEM_READDATA),
        .MEM_BUSYWAIT  (MEM_BUSYWAIT)
    );

    always #5 CLK = ~CLK;

    // Memory model: busy for 3 cycles of any request, completes on the 4th edge.
    logic [31:0] mem [64];
    int          busy_cnt = 0;
    bit          mem_init = 1'b0;

    assign MEM_BUSYWAIT = (MEM_READ | MEM_WRITE) && (busy_cnt < 3);
    assign MEM_READDATA = mem[MEM_ADDRESS];

    always @(posedge CLK) begin
        if (!mem_init) begin
            for (int i = 0; i < 64; i++) mem[i] = {4{8'(i)}};
            mem[0]   = 32'h4433_2211;
            mem[1]   = 32'h0D0C_0B0A;
            mem[9]   = 32'h9988_7766;
            mem_init = 1'b1;
            busy_cnt <= 0;
        end else if (MEM_READ | MEM_WRITE) begin
            if (busy_cnt < 3) begin
                busy_cnt <= busy_cnt + 1;
            end else begin
                busy_cnt <= 0;
                if (MEM_WRITE) mem[MEM_ADDRESS] <= MEM_WRITEDATA;
            end
        end else begin
            busy_cnt <= 0;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Drives one request until BUSYWAIT drops, profiling each stall cycle, then holds it one more edge.
    task automatic do_req(input string tag, input logic rd, input logic wr,
                          input logic [7:0] a, input logic [7:0] wd,
                          output int rd_cyc, output int wr_cyc, output int quiet_cyc,
                          output logic [7:0] rdata, output logic [5:0] wb_addr,
                          output logic [31:0] wb_data, output logic [5:0] rd_addr);
        bit done = 1'b0;
        bit both = 1'b0;
        rd_cyc = 0; wr_cyc = 0; quiet_cyc = 0;
        rdata = '0; wb_addr = '0; wb_data = '0; rd_addr = '0;
        READ = rd; WRITE = wr; ADDRESS = a; WRITEDATA = wd;
        for (int c = 0; c < 60; c++) begin
            #1;
            if (!BUSYWAIT) begin
                done = 1'b1;
                break;
            end
            if (MEM_READ && MEM_WRITE) both = 1'b1;
            if (MEM_READ) begin
                rd_cyc++;
                rd_addr = MEM_ADDRESS;
            end
            if (MEM_WRITE) begin
                wr_cyc++;
                wb_addr = MEM_ADDRESS;
                wb_data = MEM_WRITEDATA;
            end
            if (!MEM_READ && !MEM_WRITE) quiet_cyc++;
            @(posedge CLK); #1;
        end
        check({tag, "_completes"}, 32'(done), 32'd1);
        check({tag, "_rd_wr_exclusive"}, 32'(both), 32'd0);
        rdata = READDATA;
        @(posedge CLK); #1;
        READ = 1'b0; WRITE = 1'b0;
    endtask

    int          rc, wc, qc;
    logic [7:0]  rdat;
    logic [5:0]  wba, rda;
    logic [31:0] wbd;
    logic [7:0]  exp_bytes [3];

    initial begin
        RESET = 1'b0; READ = 1'b0; WRITE = 1'b0; ADDRESS = '0; WRITEDATA = '0;
        exp_bytes[0] = 8'h22; exp_bytes[1] = 8'h33; exp_bytes[2] = 8'h44;
        repeat (2) @(posedge CLK);
        #1;
        check("rst_busywait",  32'(BUSYWAIT), 32'd0);
        check("rst_mem_read",  32'(MEM_READ), 32'd0);
        check("rst_mem_write", 32'(MEM_WRITE), 32'd0);
        check("rst_readdata",  32'(READDATA), 32'd0);
        check("rst_mem_addr",  32'(MEM_ADDRESS), 32'd0);
        check("rst_mem_wdata", MEM_WRITEDATA, 32'd0);
        RESET = 1'b1;
        @(posedge CLK); #1;

        // 1: cold read miss on block 0
        do_req("t1", 1'b1, 1'b0, 8'h00, 8'h00, rc, wc, qc, rdat, wba, wbd, rda);
        check("t1_mem_read_cycles", 32'(rc), 32'd4);
        check("t1_mem_write_cycles", 32'(wc), 32'd0);
        check("t1_quiet_cycles", 32'(qc), 32'd2);
        check("t1_fetch_addr", 32'(rda), 32'h00);
        check("t1_readdata", 32'(rdat), 32'h11);

        // 2: remaining bytes of block 0 hit
        for (int i = 0; i < 3; i++) begin
            do_req("t2", 1'b1, 1'b0, 8'(i + 1), 8'h00, rc, wc, qc, rdat, wba, wbd, rda);
            check("t2_stall_cycles", 32'(rc + wc + qc), 32'd0);
            check("t2_readdata", 32'(rdat), 32'(exp_bytes[i]));
        end

        // 3: write miss on clean block 1, then read back
        do_req("t3w", 1'b0, 1'b1, 8'h05, 8'hAA, rc, wc, qc, rdat, wba, wbd, rda);
        check("t3_mem_read_cycles", 32'(rc), 32'd4);
        check("t3_mem_write_cycles", 32'(wc), 32'd0);
        check("t3_fetch_addr", 32'(rda), 32'h01);
        do_req("t3r", 1'b1, 1'b0, 8'h05, 8'h00, rc, wc, qc, rdat, wba, wbd, rda);
        check("t3_read_stall", 32'(rc + wc + qc), 32'd0);
        check("t3_readdata", 32'(rdat), 32'hAA);

        // 4: conflict miss on dirty block 1 -> writeback then fetch
        do_req("t4", 1'b1, 1'b0, 8'h25, 8'h00, rc, wc, qc, rdat, wba, wbd, rda);
        check("t4_mem_write_cycles", 32'(wc), 32'd4);
        check("t4_wb_addr", 32'(wba), 32'h01);
        check("t4_wb_data", wbd, 32'h0D0C_AA0A);
        check("t4_mem_read_cycles", 32'(rc), 32'd4);
        check("t4_fetch_addr", 32'(rda), 32'h09);
        check("t4_quiet_cycles", 32'(qc), 32'd2);
        check("t4_readdata", 32'(rdat), 32'h77);
        check("t4_mem_block1", mem[1], 32'h0D0C_AA0A);

        // 5: reset during fetch wait
        READ = 1'b1; ADDRESS = 8'h10;
        @(posedge CLK); #1;
        check("t5_in_fetch", 32'(MEM_READ), 32'd1);
        RESET = 1'b0;
        @(posedge CLK); #1;
        RESET = 1'b1; READ = 1'b0;
        #1;
        check("t5_mem_read_dropped", 32'(MEM_READ), 32'd0);
        check("t5_busywait_low", 32'(BUSYWAIT), 32'd0);
        check("t5_mem_addr_zero", 32'(MEM_ADDRESS), 32'd0);
        @(posedge CLK); #1;
        do_req("t5r", 1'b1, 1'b0, 8'h00, 8'h00, rc, wc, qc, rdat, wba, wbd, rda);
        check("t5_miss_after_reset", 32'(rc), 32'd4);
        check("t5_readdata", 32'(rdat), 32'h11);

        // 6: READ+WRITE together behaves as a write hit
        do_req("t6w", 1'b1, 1'b1, 8'h00, 8'h5C, rc, wc, qc, rdat, wba, wbd, rda);
        check("t6_write_stall", 32'(rc + wc + qc), 32'd0);
        do_req("t6r", 1'b1, 1'b0, 8'h00, 8'h00, rc, wc, qc, rdat, wba, wbd, rda);
        check("t6_readdata", 32'(rdat), 32'h5C);
        do_req("t6e", 1'b1, 1'b0, 8'h20, 8'h00, rc, wc, qc, rdat, wba, wbd, rda);
        check("t6_evict_wb_cycles", 32'(wc), 32'd4);
        check("t6_evict_wb_addr", 32'(wba), 32'h00);
        check("t6_evict_wb_data", wbd, 32'h4433_225C);
        check("t6_evict_fetch_addr", 32'(rda), 32'h08);
        check("t6_evict_readdata", 32'(rdat), 32'h08);
        check("t6_mem_block0", mem[0], 32'h4433_225C);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
